ps2_keycode_tracker: RTL and testbench

- Receive end of the PS/2 keyboard link; produces the 32-bit four-key-rollover `PS2keycode` word consumed by player-2 game logic.
- Samples the raw PS/2 clock/data lines and deserialises 11-bit frames.
- Interprets make, break (F0) and extended (E0) scan-code sequences.
- Maintains a set of up to four currently-held keys, one byte per slot, 00 = empty.

---
 rtl/ps2_pkg.sv | 44 ++++
 rtl/ps2_rx_frame.sv | 93 +++++++++
 rtl/ps2_keycode_tracker.sv | 132 +++++++++++++
 tb/tb_ps2_keycode_tracker.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receive path: prefix states,
// scan-code constants and small decode helpers.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } prefix_state_e;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // Keyboard status/response bytes that never describe a key
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;

  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;

  function automatic logic is_ignored(input logic [7:0] code);
    return (code == SC_BAT_OK) || (code == SC_ACK)  || (code == SC_RESEND) ||
           (code == SC_ECHO)   || (code == SC_ERR0) || (code == SC_ERR1)   ||
           (code == SC_PAUSE);
  endfunction

  // Odd parity over data plus parity bit
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises the raw lines, shifts in 11-bit frames
// on falling clock edges and flags parity, framing and timeout errors.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       frame_good,
  output logic       frame_bad,
  output logic [7:0] frame_byte
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] dat_sync_r;
  logic                   clk_prev_r;
  logic [3:0]             bit_cnt_r;
  logic [9:0]             shift_r;
  logic [TW-1:0]          to_cnt_r;

  logic fall_s;
  logic dat_s;
  logic last_edge_s;
  logic frame_ok_s;
  logic timeout_s;

  // Edge detect and frame checks for the current cycle
  always_comb begin
    fall_s      = clk_prev_r & ~clk_sync_r[SYNC_STAGES-1];
    dat_s       = dat_sync_r[SYNC_STAGES-1];
    last_edge_s = fall_s && (bit_cnt_r == 4'd10);
    // shift_r holds bits 0..9 with the start bit at [0]; dat_s is the stop bit
    frame_ok_s  = (shift_r[0] == 1'b0) && (dat_s == 1'b1) &&
                  odd_parity_ok(shift_r[9:1]);
    timeout_s   = !fall_s && (bit_cnt_r != 4'd0) &&
                  (to_cnt_r == TW'(TIMEOUT_CYCLES - 1));
    frame_good  = last_edge_s && frame_ok_s;
    frame_bad   = (last_edge_s && !frame_ok_s) || timeout_s;
    frame_byte  = shift_r[8:1];
  end

  // Synchronisers, bit counter, shift register, timeout and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_r <= {SYNC_STAGES{1'b1}};
      dat_sync_r <= {SYNC_STAGES{1'b1}};
      clk_prev_r <= 1'b1;
      bit_cnt_r  <= 4'd0;
      shift_r    <= 10'd0;
      to_cnt_r   <= '0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], ps2_dat};
      clk_prev_r <= clk_sync_r[SYNC_STAGES-1];
      if (fall_s) begin
        to_cnt_r <= '0;
        shift_r  <= {dat_s, shift_r[9:1]};
        if (bit_cnt_r == 4'd10) begin
          bit_cnt_r <= 4'd0;
        end else begin
          bit_cnt_r <= bit_cnt_r + 4'd1;
        end
      end else if (timeout_s) begin
        bit_cnt_r <= 4'd0;
        to_cnt_r  <= '0;
      end else if (bit_cnt_r != 4'd0) begin
        to_cnt_r <= to_cnt_r + TW'(1);
      end else begin
        to_cnt_r <= '0;
      end
      byte_valid <= frame_good;
      frame_err  <= frame_bad;
      if (frame_good) begin
        byte_data <= frame_byte;
      end else begin
        byte_data <= byte_data;
      end
    end
  end

endmodule

// File: rtl/ps2_keycode_tracker.sv
// PS/2 keyboard tracker: decodes make/break/extended sequences and keeps a
// four-slot table of held keys for player-2 logic.
module ps2_keycode_tracker
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        PS2_CLK,
  input  logic        PS2_DAT,
  output logic [31:0] PS2keycode,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_err
);

  logic          rx_good_s;
  logic          rx_bad_s;
  logic [7:0]    rx_byte_s;

  prefix_state_e state_r;
  prefix_state_e next_state_s;
  logic          do_make_s;
  logic          do_break_s;
  logic          present_s;
  logic          placed_s;
  logic [3:0][7:0] slot_r;
  logic [3:0][7:0] slot_next_s;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .ps2_clk   (PS2_CLK),
    .ps2_dat   (PS2_DAT),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err),
    .frame_good(rx_good_s),
    .frame_bad (rx_bad_s),
    .frame_byte(rx_byte_s)
  );

  // Prefix FSM next state and make/break classification of the incoming byte
  always_comb begin
    next_state_s = state_r;
    do_make_s    = 1'b0;
    do_break_s   = 1'b0;
    if (rx_bad_s) begin
      next_state_s = IDLE;
    end else if (rx_good_s && !is_ignored(rx_byte_s)) begin
      case (state_r)
        IDLE: begin
          if (rx_byte_s == SC_EXT) begin
            next_state_s = EXT;
          end else if (rx_byte_s == SC_BRK) begin
            next_state_s = BRK;
          end else begin
            do_make_s = 1'b1;
          end
        end
        EXT: begin
          if (rx_byte_s == SC_BRK) begin
            next_state_s = EXT_BRK;
          end else begin
            do_make_s    = 1'b1;
            next_state_s = IDLE;
          end
        end
        BRK, EXT_BRK: begin
          do_break_s   = 1'b1;
          next_state_s = IDLE;
        end
        default: next_state_s = IDLE;
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // Slot table update: make fills the lowest empty slot, break clears matches
  always_comb begin
    slot_next_s = slot_r;
    present_s   = 1'b0;
    placed_s    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (slot_r[i] == rx_byte_s) begin
        present_s = 1'b1;
      end else begin
        present_s = present_s;
      end
    end
    if (do_break_s) begin
      for (int i = 0; i < 4; i++) begin
        if (slot_r[i] == rx_byte_s) begin
          slot_next_s[i] = 8'h00;
        end else begin
          slot_next_s[i] = slot_r[i];
        end
      end
    end else if (do_make_s && !present_s) begin
      for (int i = 0; i < 4; i++) begin
        if (!placed_s && (slot_r[i] == 8'h00)) begin
          slot_next_s[i] = rx_byte_s;
          placed_s       = 1'b1;
        end else begin
          slot_next_s[i] = slot_r[i];
        end
      end
    end else begin
      slot_next_s = slot_r;
    end
  end

  // Prefix state and slot table registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
      slot_r  <= '0;
    end else begin
      state_r <= next_state_s;
      slot_r  <= slot_next_s;
    end
  end

  assign PS2keycode = slot_r;

endmodule

// File: tb/tb_ps2_keycode_tracker.sv
// Self-checking bench for ps2_keycode_tracker: directed scenarios followed by
// randomized key events compared against a behavioural held-key model.
module tb_ps2_keycode_tracker;
  import ps2_pkg::*;

  localparam int TO = 200;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        PS2_CLK = 1'b1;
  logic        PS2_DAT = 1'b1;
  logic [31:0] PS2keycode;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int bv_cnt = 0;
  int fe_cnt = 0;

  logic [7:0] m_slot [4];
  bit         m_ext;
  bit         m_brk;
  logic [7:0] keys [8];

  ps2_keycode_tracker #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .PS2keycode(PS2keycode),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (byte_valid) bv_cnt <= bv_cnt + 1;
    if (frame_err)  fe_cnt <= fe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word();
    return {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
  endfunction

  task automatic model_clear();
    foreach (m_slot[i]) m_slot[i] = 8'h00;
    m_ext = 0;
    m_brk = 0;
  endtask

  // Held-key model written from the scan-code rules
  task automatic model_byte(input logic [7:0] b);
    bit present;
    bit placed;
    if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hE1}) return;
    if (b == 8'hE0 && !m_ext && !m_brk) begin
      m_ext = 1;
    end else if (b == 8'hF0 && !m_brk) begin
      m_brk = 1;
    end else if (m_brk) begin
      foreach (m_slot[i]) if (m_slot[i] == b) m_slot[i] = 8'h00;
      m_ext = 0;
      m_brk = 0;
    end else begin
      present = 0;
      placed  = 0;
      foreach (m_slot[i]) if (m_slot[i] == b) present = 1;
      if (!present)
        foreach (m_slot[i])
          if (!placed && m_slot[i] == 8'h00) begin
            m_slot[i] = b;
            placed = 1;
          end
      m_ext = 0;
    end
  endtask

  task automatic ps2_bit(input logic b);
    PS2_DAT = b;
    repeat (5) @(posedge Clk);
    PS2_CLK = 1'b0;
    repeat (10) @(posedge Clk);
    PS2_CLK = 1'b1;
    repeat (5) @(posedge Clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ bad_par);
    ps2_bit(1'b1);
    PS2_DAT = 1'b1;
    repeat (10) @(posedge Clk);
    @(negedge Clk);
  endtask

  // Good frame: one byte_valid pulse, byte_data updated, model advanced
  task automatic send_key(input logic [7:0] d);
    int bv0;
    bv0 = bv_cnt;
    send_frame(d, 1'b0);
    model_byte(d);
    chk("byte_valid_pulse", bv_cnt - bv0, 32'd1);
    chk("byte_data", {24'h0, byte_data}, {24'h0, d});
  endtask

  task automatic send_bad(input logic [7:0] d);
    int bv0;
    int fe0;
    bv0 = bv_cnt;
    fe0 = fe_cnt;
    send_frame(d, 1'b1);
    m_ext = 0;
    m_brk = 0;
    chk("bad_frame_err", fe_cnt - fe0, 32'd1);
    chk("bad_no_valid", bv_cnt - bv0, 32'd0);
  endtask

  initial begin
    int fe0;
    logic [7:0] k;
    keys = '{KEY_W, KEY_A, KEY_S, KEY_D, KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT};
    model_clear();

    repeat (4) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    chk("reset_keycode", PS2keycode, 32'h0);
    chk("reset_byte_data", {24'h0, byte_data}, 32'h0);
    chk("reset_byte_valid", {31'h0, byte_valid}, 32'h0);
    chk("reset_frame_err", {31'h0, frame_err}, 32'h0);

    send_key(8'h1D);
    chk("first_make", PS2keycode, 32'h0000001D);

    send_key(8'h1C); send_key(8'h1B); send_key(8'h23); send_key(8'h75);
    chk("four_full_drop", PS2keycode, 32'h231B1C1D);
    send_key(8'hF0); send_key(8'h1C);
    chk("break_hole", PS2keycode, 32'h231B001D);
    send_key(8'h75);
    chk("fill_hole", PS2keycode, 32'h231B751D);

    send_key(8'hF0); send_key(8'h1D); send_key(8'hF0); send_key(8'h1B);
    send_key(8'hF0); send_key(8'h23); send_key(8'hF0); send_key(8'h75);
    chk("all_released", PS2keycode, 32'h0);
    send_key(8'hE0); send_key(8'h74);
    chk("ext_make", PS2keycode, 32'h00000074);
    send_key(8'h74);
    chk("typematic", PS2keycode, 32'h00000074);
    send_key(8'hE0); send_key(8'hF0); send_key(8'h74);
    chk("ext_break", PS2keycode, 32'h0);
    send_key(8'hAA);
    chk("ignored_aa", PS2keycode, 32'h0);

    send_bad(8'h1D);
    chk("bad_no_insert", PS2keycode, 32'h0);
    send_key(8'hF0);
    send_bad(8'h44);
    send_key(8'h1D);
    chk("err_resets_prefix", PS2keycode, 32'h0000001D);

    // Partial frame abandoned by timeout
    fe0 = fe_cnt;
    for (int i = 0; i < 5; i++) ps2_bit(1'b0);
    PS2_DAT = 1'b1;
    repeat (TO - 40) @(posedge Clk);
    @(negedge Clk);
    chk("no_early_timeout", fe_cnt - fe0, 32'd0);
    repeat (60) @(posedge Clk);
    @(negedge Clk);
    chk("timeout_err", fe_cnt - fe0, 32'd1);
    send_key(8'h23);
    chk("after_timeout", PS2keycode, 32'h0000231D);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_keycode", PS2keycode, 32'h0);
    chk("async_rst_byte_data", {24'h0, byte_data}, 32'h0);
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    model_clear();
    repeat (3) @(negedge Clk);
    send_key(8'h1B);
    chk("post_reset_make", PS2keycode, 32'h0000001B);

    // Randomized key events against the model
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 7) == 0) send_key(8'hFA);
      if ($urandom_range(0, 1) == 1) send_key(8'hE0);
      if ($urandom_range(0, 4) < 2) send_key(8'hF0);
      k = keys[$urandom_range(0, 7)];
      send_key(k);
      chk("random_keycode", PS2keycode, model_word());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20_000_000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
